// File: rtl/chess_pkg.sv
// Shared chess encodings used by the board keeper and the renderer.
// Piece word is {colour, type}; squares are indexed y*8+x.
package chess_pkg;

  localparam int unsigned PIECE_W = 4;
  localparam int unsigned SQ_W    = 6;

  typedef logic [PIECE_W-1:0] piece_t;
  typedef logic [SQ_W-1:0]    sq_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam logic [2:0] EMPTY  = 3'b000;
  localparam logic [2:0] PAWN   = 3'b001;
  localparam logic [2:0] BISHOP = 3'b010;
  localparam logic [2:0] KNIGHT = 3'b011;
  localparam logic [2:0] ROOK   = 3'b100;
  localparam logic [2:0] QUEEN  = 3'b101;
  localparam logic [2:0] KING   = 3'b110;

  localparam piece_t EMPTY_SQ = 4'h0;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StFetch,
    StWrDst,
    StWrSrc,
    StDone
  } state_e;

  function automatic logic is_empty(piece_t p);
    return p[2:0] == EMPTY;
  endfunction

  // Pawns reaching the far rank become queens of their own colour.
  function automatic piece_t promote(piece_t p, sq_t dst);
    piece_t r;
    r = p;
    if (p == {WHITE, PAWN} && dst < 6'd8) begin
      r = {WHITE, QUEEN};
    end else if (p == {BLACK, PAWN} && dst >= 6'd56) begin
      r = {BLACK, QUEEN};
    end
    return r;
  endfunction

endpackage

// File: rtl/board_init_rom.sv
// Combinational lookup of the starting piece on each square.
module board_init_rom
  import chess_pkg::*;
(
  input  logic [SQ_W-1:0]    sq,
  output logic [PIECE_W-1:0] piece
);

  logic [2:0] back_type;

  always_comb begin
    back_type = ROOK;
    unique case (sq[2:0])
      3'd0, 3'd7: back_type = ROOK;
      3'd1, 3'd6: back_type = KNIGHT;
      3'd2, 3'd5: back_type = BISHOP;
      3'd3:       back_type = KING;
      3'd4:       back_type = QUEEN;
      default:    back_type = ROOK;
    endcase
  end

  always_comb begin
    piece = EMPTY_SQ;
    case (sq[5:3])
      3'd0:    piece = {BLACK, back_type};
      3'd1:    piece = {BLACK, PAWN};
      3'd6:    piece = {WHITE, PAWN};
      3'd7:    piece = {WHITE, back_type};
      default: piece = EMPTY_SQ;
    endcase
  end

endmodule

// File: rtl/board_state_keeper.sv
// Authoritative 64-square board: init walk, move application, overlay register
// and a registered read port for the renderer.
module board_state_keeper
  import chess_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mv_valid,
  output logic               mv_ready,
  input  logic [SQ_W-1:0]    mv_src,
  input  logic [SQ_W-1:0]    mv_dst,
  output logic               mv_done,
  output logic               mv_err,
  output logic [PIECE_W-1:0] mv_captured,
  input  logic               avail_load,
  input  logic [63:0]        avail_in,
  input  logic [SQ_W-1:0]    rd_sq,
  output logic [PIECE_W-1:0] rd_piece,
  output logic               rd_avail,
  output logic               init_busy
);

  localparam sq_t LastSq = sq_t'(INIT_CYCLES - 1);

  state_e      state_q, state_d;
  sq_t         cnt_q, cnt_d, src_q, src_d, dst_q, dst_d;
  piece_t      p_q, p_d, c_q, c_d;
  logic        err_q, err_d;
  logic [63:0] ovl_q;
  piece_t      board_q [64];

  logic   wr_en;
  sq_t    wr_sq;
  piece_t wr_data;
  piece_t rom_piece, fetch_p, fetch_c, rd_word, rd_piece_q;
  logic   reject, rd_avail_q;

  board_init_rom u_rom (
    .sq    (cnt_q),
    .piece (rom_piece)
  );

  assign fetch_p = board_q[src_q];
  assign fetch_c = board_q[dst_q];
  assign reject  = (src_q == dst_q) || is_empty(fetch_p) ||
                   (!is_empty(fetch_c) && fetch_c[3] == fetch_p[3]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    p_d     = p_q;
    c_d     = c_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_sq   = cnt_q;
    wr_data = EMPTY_SQ;
    unique case (state_q)
      StInit: begin
        wr_en   = 1'b1;
        wr_data = rom_piece;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == LastSq) state_d = StIdle;
      end
      StIdle: begin
        if (mv_valid) begin
          src_d   = mv_src;
          dst_d   = mv_dst;
          state_d = StFetch;
        end
      end
      StFetch: begin
        p_d     = fetch_p;
        c_d     = reject ? EMPTY_SQ : fetch_c;
        err_d   = reject;
        state_d = reject ? StDone : StWrDst;
      end
      StWrDst: begin
        wr_en   = 1'b1;
        wr_sq   = dst_q;
        wr_data = promote(p_q, dst_q);
        state_d = StWrSrc;
      end
      StWrSrc: begin
        wr_en   = 1'b1;
        wr_sq   = src_q;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StInit;
    endcase
    // An aborted move must not land on the board.
    if (reset) wr_en = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      p_q     <= EMPTY_SQ;
      c_q     <= EMPTY_SQ;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      p_q     <= p_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) board_q[wr_sq] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovl_q <= '0;
    end else if (avail_load && state_q != StInit) begin
      ovl_q <= avail_in;
    end else if (state_q == StDone) begin
      ovl_q <= '0;
    end
  end

  // Squares not yet reached by the init walk read as empty, hiding stale contents.
  assign rd_word = (state_q == StInit && rd_sq >= cnt_q) ? EMPTY_SQ : board_q[rd_sq];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_piece_q <= EMPTY_SQ;
      rd_avail_q <= 1'b0;
    end else begin
      rd_piece_q <= rd_word;
      rd_avail_q <= ovl_q[rd_sq];
    end
  end

  assign rd_piece    = rd_piece_q;
  assign rd_avail    = rd_avail_q;
  assign mv_ready    = state_q == StIdle;
  assign init_busy   = state_q == StInit;
  assign mv_done     = state_q == StDone;
  assign mv_err      = mv_done & err_q;
  assign mv_captured = mv_done ? c_q : EMPTY_SQ;

endmodule

// File: tb/tb_board_state_keeper.sv
// Directed and randomized checks of board_state_keeper against a square-level
// reference board kept in the bench.
module tb_board_state_keeper;

  logic        clock = 1'b0;
  logic        reset;
  logic        mv_valid;
  logic        mv_ready;
  logic [5:0]  mv_src;
  logic [5:0]  mv_dst;
  logic        mv_done;
  logic        mv_err;
  logic [3:0]  mv_captured;
  logic        avail_load;
  logic [63:0] avail_in;
  logic [5:0]  rd_sq;
  logic [3:0]  rd_piece;
  logic        rd_avail;
  logic        init_busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0]  mdl [64];
  logic [63:0] ovl;
  int          back_row [8] = '{4, 3, 2, 6, 5, 2, 3, 4};

  always #5 clock = ~clock;

  board_state_keeper #(.INIT_CYCLES(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .mv_valid    (mv_valid),
    .mv_ready    (mv_ready),
    .mv_src      (mv_src),
    .mv_dst      (mv_dst),
    .mv_done     (mv_done),
    .mv_err      (mv_err),
    .mv_captured (mv_captured),
    .avail_load  (avail_load),
    .avail_in    (avail_in),
    .rd_sq       (rd_sq),
    .rd_piece    (rd_piece),
    .rd_avail    (rd_avail),
    .init_busy   (init_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] init_piece(int s);
    int rank = s / 8;
    if (rank == 0) return 4'(8 + back_row[s % 8]);
    if (rank == 1) return 4'(8 + 1);
    if (rank == 6) return 4'(1);
    if (rank == 7) return 4'(back_row[s % 8]);
    return 4'(0);
  endfunction

  task automatic mdl_init();
    for (int s = 0; s < 64; s++) mdl[s] = init_piece(s);
    ovl = '0;
  endtask

  task automatic rd(input int s, output logic [3:0] p, output logic a);
    rd_sq = 6'(s);
    @(negedge clock);
    p = rd_piece;
    a = rd_avail;
  endtask

  task automatic chk_board(input string tag);
    logic [3:0] p;
    logic       a;
    for (int s = 0; s < 64; s++) begin
      rd(s, p, a);
      chk($sformatf("%s_piece_%0d", tag, s), 64'(p), 64'(mdl[s]));
      chk($sformatf("%s_avail_%0d", tag, s), 64'(a), 64'(ovl[s]));
    end
  endtask

  // Called on a negedge with init_busy expected high; counts busy cycles.
  task automatic init_wait(output int n, output int dones);
    n = 0;
    dones = 0;
    while (init_busy && n < 200) begin
      n++;
      if (mv_done) dones++;
      @(negedge clock);
    end
  endtask

  task automatic do_move(input int s, input int d, input bit ld, input logic [63:0] ldv);
    int         k;
    int         pcol, ptype, elat;
    bit         erej;
    logic [3:0] ecap, newp;
    pcol  = int'(mdl[s]) / 8;
    ptype = int'(mdl[s]) % 8;
    erej  = (s == d) || (ptype == 0) || (mdl[d] != 0 && int'(mdl[d]) / 8 == pcol);
    elat  = erej ? 2 : 4;
    ecap  = erej ? 4'(0) : mdl[d];
    k = 0;
    while (!mv_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("ready_before_move", 64'(mv_ready), 64'(1));
    mv_valid = 1'b1;
    mv_src   = 6'(s);
    mv_dst   = 6'(d);
    k = 0;
    do begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        mv_valid = 1'b0;
        chk("ready_low_when_busy", 64'(mv_ready), 64'(0));
      end
    end while (!mv_done && k < 20);
    chk($sformatf("done_latency_%0d_%0d", s, d), 64'(k), 64'(elat));
    chk($sformatf("err_%0d_%0d", s, d), 64'(mv_err), 64'(erej));
    chk($sformatf("captured_%0d_%0d", s, d), 64'(mv_captured), 64'(ecap));
    if (ld) begin
      avail_load = 1'b1;
      avail_in   = ldv;
    end
    @(negedge clock);
    avail_load = 1'b0;
    chk("ready_after_done", 64'(mv_ready), 64'(1));
    chk("done_is_pulse", 64'(mv_done), 64'(0));
    if (!erej) begin
      newp = mdl[s];
      if (ptype == 1 && ((pcol == 0 && d < 8) || (pcol == 1 && d >= 56))) newp = 4'(pcol * 8 + 5);
      mdl[d] = newp;
      mdl[s] = 4'(0);
    end
    ovl = ld ? ldv : 64'(0);
  endtask

  task automatic load_overlay(input logic [63:0] v);
    avail_load = 1'b1;
    avail_in   = v;
    @(negedge clock);
    avail_load = 1'b0;
    ovl = v;
  endtask

  initial begin
    logic [3:0]  p;
    logic        a;
    int          n, dones, s, d, probe;
    logic [63:0] v;

    reset      = 1'b1;
    mv_valid   = 1'b0;
    mv_src     = '0;
    mv_dst     = '0;
    avail_load = 1'b0;
    avail_in   = '0;
    rd_sq      = '0;
    repeat (3) @(negedge clock);
    chk("rst_init_busy", 64'(init_busy), 64'(1));
    chk("rst_mv_ready", 64'(mv_ready), 64'(0));
    chk("rst_mv_done", 64'(mv_done), 64'(0));
    chk("rst_mv_err", 64'(mv_err), 64'(0));
    chk("rst_mv_captured", 64'(mv_captured), 64'(0));
    chk("rst_rd_piece", 64'(rd_piece), 64'(0));
    chk("rst_rd_avail", 64'(rd_avail), 64'(0));

    reset = 1'b0;
    init_wait(n, dones);
    chk("init_busy_cycles", 64'(n), 64'(64));
    chk("init_no_done", 64'(dones), 64'(0));
    chk("init_ready", 64'(mv_ready), 64'(1));
    mdl_init();

    rd(3, p, a);
    chk("rd3_black_king", 64'(p), 64'(4'b1110));
    rd(59, p, a);
    chk("rd59_white_king", 64'(p), 64'(4'b0110));
    rd(30, p, a);
    chk("rd30_empty", 64'(p), 64'(0));
    chk_board("init");

    do_move(52, 36, 1'b0, '0);
    rd(36, p, a);
    chk("rd36_pawn", 64'(p), 64'(4'b0001));
    rd(52, p, a);
    chk("rd52_empty", 64'(p), 64'(0));

    do_move(57, 48, 1'b0, '0);
    rd(57, p, a);
    chk("rd57_knight_kept", 64'(p), 64'(4'b0011));
    rd(48, p, a);
    chk("rd48_pawn_kept", 64'(p), 64'(4'b0001));

    do_move(36, 9, 1'b0, '0);
    do_move(9, 0, 1'b0, '0);
    rd(0, p, a);
    chk("rd0_promoted_queen", 64'(p), 64'(4'b0101));

    load_overlay(64'h0000_0000_0014_0000);
    rd(18, p, a);
    chk("avail18_loaded", 64'(a), 64'(1));
    rd(20, p, a);
    chk("avail20_loaded", 64'(a), 64'(1));
    rd(19, p, a);
    chk("avail19_clear", 64'(a), 64'(0));
    do_move(50, 34, 1'b0, '0);
    chk_board("ovl_cleared");
    load_overlay(64'h0000_0000_0014_0000);
    do_move(51, 35, 1'b1, 64'h8000_0000_0000_0401);
    chk_board("ovl_load_in_done");

    for (int it = 0; it < 40; it++) begin
      s = -1;
      for (int t = 0; t < 200 && s < 0; t++) begin
        n = int'($urandom_range(63));
        if (mdl[n] != 0) s = n;
      end
      if (s < 0) s = 0;
      d = ($urandom_range(9) == 0) ? s : int'($urandom_range(63));
      if ($urandom_range(3) == 0) begin
        load_overlay({$urandom, $urandom});
        n = int'($urandom_range(63));
        rd(n, p, a);
        chk($sformatf("rand_avail_%0d", n), 64'(a), 64'(ovl[n]));
      end
      v = {$urandom, $urandom};
      do_move(s, d, $urandom_range(3) == 0, v);
      for (int j = 0; j < 2; j++) begin
        n = int'($urandom_range(63));
        rd(n, p, a);
        chk($sformatf("rand_piece_%0d", n), 64'(p), 64'(mdl[n]));
        chk($sformatf("rand_avail_%0d", n), 64'(a), 64'(ovl[n]));
      end
    end
    chk_board("after_random");

    // Abort a move with reset during its write phase.
    s = 0;
    for (int i = 63; i >= 0; i--) if (mdl[i] != 0 && s == 0) s = i;
    probe = s;
    d = (s == 0) ? 1 : 0;
    chk("abort_ready", 64'(mv_ready), 64'(1));
    mv_valid = 1'b1;
    mv_src   = 6'(s);
    mv_dst   = 6'(d);
    @(negedge clock);
    mv_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_no_done_a3", 64'(mv_done), 64'(0));
    @(negedge clock);
    chk("abort_no_done_a4", 64'(mv_done), 64'(0));
    rd_sq = 6'(probe);
    reset = 1'b0;
    @(negedge clock);
    chk("init_unwritten_reads_empty", 64'(rd_piece), 64'(0));
    init_wait(n, dones);
    // One busy cycle was already consumed by the probe read above.
    chk("reinit_busy_cycles", 64'(n), 64'(63));
    chk("reinit_no_done", 64'(dones), 64'(0));
    mdl_init();
    chk_board("reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
